// File: rtl/d16_wb_ram.sv
// ---------------------------------------------------------------------------
// d16_wb_ram
//   Wishbone responder for the d16 core's master port: a word-addressed
//   16-bit RAM behind a decoded address window, with programmable wait
//   states, an optional read-only low region and bus-error signalling.
//
// Handshake: there is no STB. i_wb_cyc alone qualifies a cycle. The master
//   raises i_wb_cyc with we/addr/dat valid and holds it until it sees a
//   one-cycle o_wb_ack (success) or o_wb_err (error). Dropping i_wb_cyc
//   before the response abandons the access with no side effects.
//
// Parameters
//   BASE        first word address of the window
//   DEPTH_LOG2  log2 of RAM depth in 16-bit words
//   WAIT        wait states inserted before the response (0..15)
//   RO_WORDS    words BASE..BASE+RO_WORDS-1 are read-only (writes -> err)
//
// Ports
//   i_clk        clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_wb_cyc     cycle request, held until ack/err
//   i_wb_we      1 = write, 0 = read
//   i_wb_addr    word address
//   i_wb_dat     write data
//   o_wb_dat     read data, holds the last successful read
//   o_wb_ack     success, one-cycle pulse
//   o_wb_err     error, one-cycle pulse
//   o_dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
// ---------------------------------------------------------------------------
module d16_wb_ram #(
    parameter logic [15:0] BASE       = 16'h0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          WAIT       = 1,
    parameter int          RO_WORDS   = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_addr,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [1:0]  o_dbg_state
);

    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    // 17-bit limits so a full 64K-word window still compares correctly.
    localparam logic [16:0] DEPTH_WORDS = 17'(DEPTH);
    localparam logic [16:0] RO_LIMIT    = 17'(RO_WORDS);
    localparam logic [3:0]  WAIT_CNT    = 4'(WAIT);
    localparam logic        NO_WAIT     = (WAIT == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_n;
    logic [3:0]  cnt, cnt_n;

    logic [15:0] mem [0:DEPTH-1];

    // Access latched in IDLE and used for the rest of the transaction.
    logic                  lat_we;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [15:0]           lat_dat;
    logic                  lat_hit;
    logic                  lat_ro;

    // Decode of the live bus. Unsigned wrap makes addresses below BASE miss.
    logic [15:0] in_off;
    logic        in_hit;
    logic        in_ro;

    always_comb begin
        in_off = i_wb_addr - BASE;
        in_hit = ({1'b0, in_off} < DEPTH_WORDS);
        in_ro  = in_hit && ({1'b0, in_off} < RO_LIMIT);
    end

    // With WAIT=0 the response is decided on the sampling edge itself, so the
    // live decode is used in IDLE; every later state uses the latched copy.
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [15:0]           acc_dat;
    logic                  acc_hit;
    logic                  acc_ro;

    always_comb begin
        if (state == ST_IDLE) begin
            acc_we  = i_wb_we;
            acc_idx = in_off[DEPTH_LOG2-1:0];
            acc_dat = i_wb_dat;
            acc_hit = in_hit;
            acc_ro  = in_ro;
        end else begin
            acc_we  = lat_we;
            acc_idx = lat_idx;
            acc_dat = lat_dat;
            acc_hit = lat_hit;
            acc_ro  = lat_ro;
        end
    end

    logic latch_en;
    logic enter_resp;
    logic resp_ok;
    logic mem_wr;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        latch_en   = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_wb_cyc) begin
                    latch_en = 1'b1;
                    if (NO_WAIT) begin
                        state_n    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_n   = WAIT_CNT;
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        resp_ok = enter_resp && acc_hit && !(acc_we && acc_ro);
        // Reset gating keeps a held WAIT=0 write from landing while in reset.
        mem_wr  = resp_ok && acc_we && i_reset_n;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 16'h0000;
            lat_we   <= 1'b0;
            lat_idx  <= '0;
            lat_dat  <= 16'h0000;
            lat_hit  <= 1'b0;
            lat_ro   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            o_wb_ack <= resp_ok;
            o_wb_err <= enter_resp && !resp_ok;
            if (resp_ok && !acc_we) begin
                o_wb_dat <= mem[acc_idx];
            end
            if (latch_en) begin
                lat_we  <= i_wb_we;
                lat_idx <= in_off[DEPTH_LOG2-1:0];
                lat_dat <= i_wb_dat;
                lat_hit <= in_hit;
                lat_ro  <= in_ro;
            end
        end
    end

    // RAM array has no reset: contents survive i_reset_n.
    always_ff @(posedge i_clk) begin
        if (mem_wr) begin
            mem[acc_idx] <= acc_dat;
        end
    end

    assign o_dbg_state = state;

endmodule
